// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MULT_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int MULT_CNT_W = cnt_width(MULT_WIDTH);

endpackage

// File: rtl/twos_neg.sv
// Conditional two's-complement negate: o_val = i_neg ? -i_val : i_val.
module twos_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mult_seq.sv
// Sequential MULT/MULTU: one shift-add step per cycle over unsigned magnitudes,
// sign applied to the 2*WIDTH product as it is registered into hi/lo.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH == MULT_WIDTH) ? MULT_CNT_W : cnt_width(WIDTH);

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_step;
    logic                 w_last;

    logic [CNT_W-1:0]     r_cnt;
    logic                 r_signed;
    logic                 r_sign_xor;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_product;

    // Magnitudes stay unsigned in WIDTH bits, so the most negative operand is exact.
    twos_neg #(.W(WIDTH)) u_neg_a (
        .i_val (multiplicand),
        .i_neg (is_signed & multiplicand[WIDTH-1]),
        .o_val (w_mag_a)
    );

    twos_neg #(.W(WIDTH)) u_neg_b (
        .i_val (multiplier),
        .i_neg (is_signed & multiplier[WIDTH-1]),
        .o_val (w_mag_b)
    );

    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

    // Sign is applied to the step-(WIDTH-1) accumulator so hi/lo load in the same edge.
    twos_neg #(.W(2*WIDTH)) u_neg_p (
        .i_val (w_acc_next),
        .i_neg (r_signed & r_sign_xor),
        .o_val (w_product)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH-1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_signed   <= 1'b0;
            r_sign_xor <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_signed   <= is_signed;
            r_sign_xor <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
            r_mcand    <= w_mag_a;
            r_mplier   <= w_mag_b;
            r_acc      <= '0;
        end else if (w_step) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
                {r_hi, r_lo} <= w_product;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
